alu_share_ctrl: RTL and testbench

Two-port arbiter and sequencer for the shared clocked ALU (`alu_top`). It accepts operation requests from two requesters and grants them round-robin. It drives the ALU operands and function code from registers, waits a fixed ALU latency, and returns the captured result and overflow flag to the winning requester with a one-cycle done pulse. The block sits between the front-end requesters (switch/keypad sequencers) and `alu_top`; the display path reads its result register.

---
 rtl/alu_share_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer for the shared clocked ALU: grants one of two requesters,
// issues registered operands, waits ALU_LAT cycles, captures the result and pulses done.
module alu_share_ctrl #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic [2:0]         func0,
  input  logic [2:0]         func1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] res,
  output logic               res_err,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_ovf
);

  localparam logic [2:0] LatCnt = 3'(ALU_LAT);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]         alu_func_q, alu_func_d;

  logic       win;
  logic [2:0] win_func;

  // On a tie the requester that did not win last time takes the grant.
  assign win      = (req0 && req1) ? ~last_q : req1;
  assign win_func = win ? func1 : func0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    res_d      = res_q;
    err_d      = err_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d    = StWait;
          owner_d    = win;
          last_d     = win;
          cnt_d      = '0;
          gnt0_d     = ~win;
          gnt1_d     = win;
          // Chain mode feeds the previous result back as operand A.
          alu_a_d    = win_func[2] ? res_q[WIDTH-1:0] : (win ? a1 : a0);
          alu_b_d    = win ? b1 : b0;
          alu_func_d = win_func[1:0];
        end
      end
      StWait: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LatCnt) begin
          res_d   = alu_out;
          err_d   = alu_ovf;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      res_q      <= res_d;
      err_q      <= err_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = (state_q == StDone) && !owner_q;
  assign done1    = (state_q == StDone) && owner_q;
  assign busy     = (state_q != StIdle);
  assign res      = res_q;
  assign res_err  = err_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU_LAT=1 and ALU_LAT=3 instances, each driving a pipelined ALU model;
// a done-driven scoreboard checks every returned result.
module tb_alu_share_ctrl;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0 = 0, req1 = 0, l_req0 = 0, l_req1 = 0;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0]   func0 = 0, func1 = 0;

  logic gnt0, gnt1, done0, done1, busy, res_err, alu_ovf;
  logic [2*W-1:0] res, alu_out;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0] alu_func;

  logic l_gnt0, l_gnt1, l_done0, l_done1, l_busy, l_res_err, l_alu_ovf;
  logic [2*W-1:0] l_res, l_alu_out;
  logic [W-1:0] l_alu_a, l_alu_b;
  logic [1:0] l_alu_func;

  alu_share_ctrl #(.WIDTH(W), .ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .func0(func0), .func1(func1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .res_err(res_err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_func(alu_func), .alu_out(alu_out), .alu_ovf(alu_ovf)
  );

  alu_share_ctrl #(.WIDTH(W), .ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req0(l_req0), .req1(l_req1), .a0(a0), .b0(b0), .a1(a1),
    .b1(b1), .func0(func0), .func1(func1), .gnt0(l_gnt0), .gnt1(l_gnt1), .done0(l_done0),
    .done1(l_done1), .res(l_res), .res_err(l_res_err), .busy(l_busy), .alu_a(l_alu_a),
    .alu_b(l_alu_b), .alu_func(l_alu_func), .alu_out(l_alu_out), .alu_ovf(l_alu_ovf)
  );

  // ALU model: 00 add (overflow above 2^W-1), 01 multiply, others 0.
  function automatic logic [2*W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] fn);
    logic [2*W-1:0] r;
    r = '0;
    if (fn == 2'd0) begin
      r = (2*W)'(a) + (2*W)'(b);
      return {(r > (2*W)'((1 << W) - 1)), r};
    end
    if (fn == 2'd1) r = (2*W)'(a) * (2*W)'(b);
    return {1'b0, r};
  endfunction

  logic [2*W:0] p1;
  logic [2*W:0] p3 [3];
  always @(posedge clk) begin
    p1    <= alu_f(alu_a, alu_b, alu_func);
    p3[0] <= alu_f(l_alu_a, l_alu_b, l_alu_func);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {alu_ovf, alu_out}     = p1;
  assign {l_alu_ovf, l_alu_out} = p3[2];

  int applied = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic           who;
    logic [2*W-1:0] res;
    logic           err;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard for the ALU_LAT=1 instance: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones({gnt0, gnt1, done0, done1}) > 1) begin
        miscompares++;
        $display("FAIL onehot: gnt/done = %b", {gnt0, gnt1, done0, done1});
      end
      if (done0 || done1) begin
        if (sbq.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL done_unexpected: done=%b%b res=%0d", done1, done0, res);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_who", 32'(done1), 32'(e.who));
          check("res", 32'(res), 32'(e.res));
          check("res_err", 32'(res_err), 32'(e.err));
        end
      end
    end
  end

  typedef struct {
    logic r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0] f0, f1;
    logic who;
    logic [W-1:0] alu_a;
    logic [2*W-1:0] res;
    logic err;
  } vec_t;
  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    logic got;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    func0 = v.f0; func1 = v.f1;
    sbq.push_back('{v.who, v.res, v.err});
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin got = 1; break; end
    end
    check("gnt_seen", 32'(got), 1);
    check("gnt_who", 32'(gnt1), 32'(v.who));
    check("alu_a", 32'(alu_a), 32'(v.alu_a));
    req0 = 0; req1 = 0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1) begin got = 1; break; end
    end
    check("done_seen", 32'(got), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out"}, 32'({gnt0, gnt1, done0, done1, busy, res_err}), 0);
    check({tag, "_res"}, 32'(res), 0);
    check({tag, "_alu"}, 32'({alu_a, alu_b, alu_func}), 0);
  endtask

  initial begin
    int gcyc[3];
    logic gwho[3];
    int ng;
    // Table: runs after the tie sequence, which leaves the last-grant pointer at 0.
    vecs[0] = '{0, 1, 0, 0, 3, 4, 3'b000, 3'b001, 1, 3, 12, 0};
    vecs[1] = '{1, 0, 9, 2, 0, 0, 3'b100, 3'b000, 0, 12, 14, 0};
    vecs[2] = '{1, 1, 1, 1, 10, 20, 3'b000, 3'b000, 1, 10, 30, 0};
    vecs[3] = '{1, 1, 40, 30, 1, 1, 3'b000, 3'b000, 0, 40, 70, 1};
    vecs[4] = '{0, 1, 0, 0, 63, 63, 3'b000, 3'b001, 1, 63, 3969, 0};
    vecs[5] = '{0, 1, 0, 0, 7, 2, 3'b000, 3'b101, 1, 1, 2, 0};
    vecs[6] = '{1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0};
    vecs[7] = '{1, 0, 63, 0, 0, 0, 3'b000, 3'b000, 0, 63, 63, 0};

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // Single request: exact cycle timing.
    @(negedge clk);
    req0 = 1; a0 = 5; b0 = 7; func0 = 3'b000;
    sbq.push_back('{0, 12, 0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req0 = 0;
      check($sformatf("t1_gnt0_c%0d", c), 32'(gnt0), 32'(c == 1));
      check($sformatf("t1_done0_c%0d", c), 32'(done0), 32'(c == 3));
      check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 3));
    end

    // Fresh reset so the pointer is back at 1; tie held for three ops.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0 = 1; req1 = 1; a0 = 2; b0 = 3; func0 = 3'b000; a1 = 4; b1 = 5; func1 = 3'b001;
    sbq.push_back('{0, 5, 0});
    sbq.push_back('{1, 20, 0});
    sbq.push_back('{0, 5, 0});
    ng = 0;
    for (int c = 1; c <= 30 && ng < 3; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        gcyc[ng] = c;
        gwho[ng] = gnt1;
        ng++;
        if (ng == 3) begin req0 = 0; req1 = 0; end
      end
    end
    check("t2_ngrants", 32'(ng), 3);
    check("t2_order", 32'({gwho[0], gwho[1], gwho[2]}), 32'(3'b010));
    check("t2_period_a", 32'(gcyc[1] - gcyc[0]), 4);
    check("t2_period_b", 32'(gcyc[2] - gcyc[1]), 4);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    check("t2_drained", 32'(sbq.size()), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Request raised while busy: held and serviced at the next IDLE; res holds meanwhile.
    @(negedge clk);
    @(negedge clk);
    req0 = 1; a0 = 20; b0 = 2; func0 = 3'b001;
    a1 = 30; b1 = 40; func1 = 3'b000;
    sbq.push_back('{0, 40, 0});
    sbq.push_back('{1, 70, 1});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin req0 = 0; req1 = 1; end
      if (c == 5) req1 = 0;
      check($sformatf("t6_gnt1_c%0d", c), 32'(gnt1), 32'(c == 5));
      if (c >= 4 && c <= 6) check($sformatf("t6_hold_c%0d", c), 32'(res), 40);
    end

    // Reset during the second WAIT cycle.
    @(negedge clk);
    req0 = 1; a0 = 11; b0 = 12; func0 = 3'b000;
    sbq.push_back('{0, 23, 0});
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    rst_n = 0;
    sbq.delete();
    #1;
    check_idle_outputs("t5_async");
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_nodone_c%0d", c), 32'({done0, done1}), 0);
    end
    run_vec('{0, 1, 0, 0, 2, 2, 3'b000, 3'b000, 1, 2, 4, 0});

    // ALU_LAT=3 instance: overflow at the top of the operand range.
    @(negedge clk);
    l_req0 = 1; a0 = 63; b0 = 1; func0 = 3'b000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      l_req0 = 0;
      check($sformatf("t4_gnt0_c%0d", c), 32'(l_gnt0), 32'(c == 1));
      check($sformatf("t4_done0_c%0d", c), 32'(l_done0), 32'(c == 5));
      if (c == 5) begin
        check("t4_res", 32'(l_res), 64);
        check("t4_err", 32'(l_res_err), 1);
      end
    end
    check("t4_busy_end", 32'(l_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
